// File: rtl/rect_fill_ctrl.sv
// Rectangle fill engine for the 160x120x3 framebuffer write port.
// Ports: CLOCK_50/rst_n; cmd_* valid/ready command; abort; we/xw/yw/din RAM write; busy/done/pix_count status.
module rect_fill_ctrl #(
    parameter int XMAX = 159,
    parameter int YMAX = 119
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x0,
    input  logic [6:0]  cmd_y0,
    input  logic [7:0]  cmd_x1,
    input  logic [6:0]  cmd_y1,
    input  logic [2:0]  cmd_color,
    input  logic        abort,
    output logic        we,
    output logic [7:0]  xw,
    output logic [6:0]  yw,
    output logic [2:0]  din,
    output logic        busy,
    output logic        done,
    output logic [14:0] pix_count
);

    localparam logic [7:0] XLIM = 8'(XMAX);
    localparam logic [6:0] YLIM = 7'(YMAX);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  xa, xb, x_lo, x_hi, xa_c, xb_c;
    logic [6:0]  ya, yb, y_lo, y_hi, ya_c, yb_c;
    logic        accept, fill_st, last;
    logic [7:0]  xw_d;
    logic [6:0]  yw_d;
    logic [2:0]  din_d;
    logic [14:0] pix_d;
    logic        we_d, busy_d, done_d, ready_d;

    // Corner ordering then clamping to the visible area.
    always_comb begin
        x_lo = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        x_hi = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        y_lo = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        y_hi = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
        xa_c = (x_lo > XLIM) ? XLIM : x_lo;
        xb_c = (x_hi > XLIM) ? XLIM : x_hi;
        ya_c = (y_lo > YLIM) ? YLIM : y_lo;
        yb_c = (y_hi > YLIM) ? YLIM : y_hi;
    end

    assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
    assign fill_st = (state == FILL);
    assign last    = (xw == xb) && (yw == yb);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = FILL;
            FILL:    if (abort || last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; the write on the
    // outputs when abort is seen still counts as written.
    always_comb begin
        we_d    = (state_nx == FILL);
        busy_d  = (state_nx == FILL);
        done_d  = (state_nx == DONE);
        ready_d = (state_nx == IDLE);
        xw_d    = xw;
        yw_d    = yw;
        din_d   = din;
        pix_d   = pix_count;
        unique case (1'b1)
            accept: begin
                xw_d  = xa_c;
                yw_d  = ya_c;
                din_d = cmd_color;
                pix_d = '0;
            end
            fill_st: begin
                pix_d = pix_count + 15'd1;
                if (!abort && !last) begin
                    if (xw == xb) begin
                        xw_d = xa;
                        yw_d = yw + 7'd1;
                    end else begin
                        xw_d = xw + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b1;
            we        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            xw        <= '0;
            yw        <= '0;
            din       <= '0;
            pix_count <= '0;
            xa        <= '0;
            xb        <= '0;
            ya        <= '0;
            yb        <= '0;
        end else begin
            cmd_ready <= ready_d;
            we        <= we_d;
            busy      <= busy_d;
            done      <= done_d;
            xw        <= xw_d;
            yw        <= yw_d;
            din       <= din_d;
            pix_count <= pix_d;
            if (accept) begin
                xa <= xa_c;
                xb <= xb_c;
                ya <= ya_c;
                yb <= yb_c;
            end
        end
    end

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Directed bench for rect_fill_ctrl.
// Drives commands/abort/reset and checks every write and status cycle.
module tb_rect_fill_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0, cmd_x1;
    logic [6:0]  cmd_y0, cmd_y1;
    logic [2:0]  cmd_color;
    logic        abort;
    logic        we;
    logic [7:0]  xw;
    logic [6:0]  yw;
    logic [2:0]  din;
    logic        busy, done;
    logic [14:0] pix_count;

    int checks   = 0;
    int failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    rect_fill_ctrl dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .abort     (abort),
        .we        (we),
        .xw        (xw),
        .yw        (yw),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cmd(input int x0, input int y0, input int x1,
                           input int y1, input int c);
        cmd_x0    = 8'(x0);
        cmd_y0    = 7'(y0);
        cmd_x1    = 8'(x1);
        cmd_y1    = 7'(y1);
        cmd_color = 3'(c);
        cmd_valid = 1'b1;
    endtask

    task automatic send(input int x0, input int y0, input int x1,
                        input int y1, input int c);
        set_cmd(x0, y0, x1, y1, c);
        @(posedge CLOCK_50);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic expect_pixels(input int xa, input int xb, input int ya,
                                 input int yb, input int c);
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                @(negedge CLOCK_50);
                chk("px_we", we, 1);
                chk("px_x", xw, x);
                chk("px_y", yw, y);
                chk("px_din", din, c);
                chk("px_busy", busy, 1);
            end
        end
    endtask

    task automatic expect_done(input int n);
        @(negedge CLOCK_50);
        chk("dn_we", we, 0);
        chk("dn_done", done, 1);
        chk("dn_busy", busy, 0);
        chk("dn_ready", cmd_ready, 0);
        chk("dn_pix", pix_count, n);
        @(negedge CLOCK_50);
        chk("id_done", done, 0);
        chk("id_ready", cmd_ready, 1);
        chk("id_we", we, 0);
        chk("id_pix", pix_count, n);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_x1    = '0;
        cmd_y1    = '0;
        cmd_color = '0;
        #23 rst_n = 1'b1;
        @(negedge CLOCK_50);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_we", we, 0);
        chk("rst_xw", xw, 0);
        chk("rst_yw", yw, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix", pix_count, 0);

        // Basic 3x2 fill; abort held high in IDLE must be ignored.
        abort = 1'b1;
        send(2, 3, 4, 4, 5);
        abort = 1'b0;
        expect_pixels(2, 4, 3, 4, 5);
        expect_done(6);

        // Swapped corners, then a command held valid through DONE.
        send(10, 9, 8, 7, 1);
        expect_pixels(8, 10, 7, 9, 1);
        @(negedge CLOCK_50);
        chk("b2b_done", done, 1);
        chk("b2b_ready", cmd_ready, 0);
        chk("b2b_pix", pix_count, 9);
        set_cmd(150, 115, 255, 127, 7);
        @(posedge CLOCK_50);
        #1;
        chk("b2b_idle_we", we, 0);
        chk("b2b_idle_rdy", cmd_ready, 1);
        chk("b2b_idle_pix", pix_count, 9);
        @(posedge CLOCK_50);
        #1 cmd_valid = 1'b0;
        expect_pixels(150, 159, 115, 119, 7);
        expect_done(50);

        // Full-screen clear.
        send(0, 0, 159, 119, 0);
        expect_pixels(0, 159, 0, 119, 0);
        expect_done(19200);

        // Abort on the 4th write of a 5x5 fill.
        send(20, 20, 24, 24, 6);
        expect_pixels(20, 22, 20, 20, 6);
        @(negedge CLOCK_50);
        chk("ab_px4_we", we, 1);
        chk("ab_px4_x", xw, 23);
        chk("ab_px4_y", yw, 20);
        abort = 1'b1;
        @(posedge CLOCK_50);
        #1 abort = 1'b0;
        @(negedge CLOCK_50);
        chk("ab_we", we, 0);
        chk("ab_done", done, 1);
        chk("ab_pix", pix_count, 4);
        chk("ab_xhold", xw, 23);
        chk("ab_yhold", yw, 20);
        chk("ab_dinhold", din, 6);
        @(negedge CLOCK_50);
        chk("ab_idle_rdy", cmd_ready, 1);
        chk("ab_idle_done", done, 0);
        send(5, 6, 5, 6, 3);
        expect_pixels(5, 5, 6, 6, 3);
        expect_done(1);

        // Reset in the middle of a fill.
        send(0, 0, 9, 9, 2);
        expect_pixels(0, 4, 0, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_we", we, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_ready", cmd_ready, 1);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        chk("mr_post_done", done, 0);
        chk("mr_post_we", we, 0);
        chk("mr_post_rdy", cmd_ready, 1);
        chk("mr_post_pix", pix_count, 0);
        send(7, 8, 7, 8, 4);
        expect_pixels(7, 7, 8, 8, 4);
        expect_done(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
